data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester, memory and status signals shared between the data memory
// arbiter (slave modport) and the agents that drive it (master modport).
interface data_mem_arbiter_if;
    logic        r0_req;
    logic        r0_write;
    logic [31:0] r0_address;
    logic [31:0] r0_writedata;
    logic        r0_done;
    logic        r0_err;
    logic [31:0] r0_readdata;

    logic        r1_req;
    logic        r1_write;
    logic [31:0] r1_address;
    logic [31:0] r1_writedata;
    logic        r1_done;
    logic        r1_err;
    logic [31:0] r1_readdata;

    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic        busy;
    logic        last_grant;

    modport slave (
        input  r0_req, r0_write, r0_address, r0_writedata,
        output r0_done, r0_err, r0_readdata,
        input  r1_req, r1_write, r1_address, r1_writedata,
        output r1_done, r1_err, r1_readdata,
        output data_address, data_write, data_read, data_writedata,
        input  data_readdata,
        output busy, last_grant
    );

    modport master (
        output r0_req, r0_write, r0_address, r0_writedata,
        input  r0_done, r0_err, r0_readdata,
        output r1_req, r1_write, r1_address, r1_writedata,
        input  r1_done, r1_err, r1_readdata,
        input  data_address, data_write, data_read, data_writedata,
        output data_readdata,
        input  busy, last_grant
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter onto a single data memory port: one access
// every three cycles, misaligned accesses complete with an error and no strobe.
module data_mem_arbiter (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] address_reg, address_next;
    logic [31:0] writedata_reg, writedata_next;
    logic        op_write_reg, op_write_next;
    logic        grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic        err_reg, err_next;

    logic [1:0]  req;
    logic        req_write     [2];
    logic [31:0] req_address   [2];
    logic [31:0] req_writedata [2];
    logic        grant_sel;
    logic [1:0]  done;
    logic [1:0]  err;

    assign req              = {bus.r1_req, bus.r0_req};
    assign req_write[0]     = bus.r0_write;
    assign req_write[1]     = bus.r1_write;
    assign req_address[0]   = bus.r0_address;
    assign req_address[1]   = bus.r1_address;
    assign req_writedata[0] = bus.r0_writedata;
    assign req_writedata[1] = bus.r1_writedata;

    // A tie goes to whichever requester was not served last.
    assign grant_sel = (req == 2'b11) ? ~last_grant_reg : req[1];

    always_comb begin
        state_next      = state_reg;
        address_next    = address_reg;
        writedata_next  = writedata_reg;
        op_write_next   = op_write_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        err_next        = err_reg;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_next      = grant_sel;
                    last_grant_next = grant_sel;
                    address_next    = req_address[grant_sel];
                    writedata_next  = req_writedata[grant_sel];
                    op_write_next   = req_write[grant_sel];
                    if (req_address[grant_sel][1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = COMPLETE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE:    state_next = COMPLETE;
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            address_reg    <= '0;
            writedata_reg  <= '0;
            op_write_reg   <= 1'b0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            err_reg        <= 1'b0;
        end else if (clk_enable) begin
            state_reg      <= state_next;
            address_reg    <= address_next;
            writedata_reg  <= writedata_next;
            op_write_reg   <= op_write_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            err_reg        <= err_next;
        end
    end

    // Per-requester load data and completion flags; done/err decode from the
    // held state so a frozen clock stretches a pulse rather than repeating it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [31:0] readdata_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    readdata_reg <= '0;
                end else if (clk_enable && (state_reg == ISSUE) && !op_write_reg
                             && (grant_reg == 1'(gi))) begin
                    readdata_reg <= bus.data_readdata;
                end
            end

            assign done[gi] = (state_reg == COMPLETE) && (grant_reg == 1'(gi));
            assign err[gi]  = done[gi] && err_reg;
        end
    endgenerate

    assign bus.r0_done        = done[0];
    assign bus.r0_err         = err[0];
    assign bus.r0_readdata    = g_req[0].readdata_reg;
    assign bus.r1_done        = done[1];
    assign bus.r1_err         = err[1];
    assign bus.r1_readdata    = g_req[1].readdata_reg;

    assign bus.data_address   = address_reg;
    assign bus.data_writedata = writedata_reg;
    assign bus.data_read      = (state_reg == ISSUE) && !op_write_reg;
    assign bus.data_write     = (state_reg == ISSUE) && op_write_reg;
    assign bus.busy           = (state_reg != IDLE);
    assign bus.last_grant     = last_grant_reg;
endmodule
